// File: rtl/irq_mmio_pkg.sv
// Shared register map, decode selector and priority helper for irq_mmio_ctrl.
package irq_mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h0000_0200;

  localparam logic [31:0] OFF_ENABLE  = 32'h0;
  localparam logic [31:0] OFF_PENDING = 32'h4;
  localparam logic [31:0] OFF_SWSET   = 32'h8;
  localparam logic [31:0] OFF_ACTIVE  = 32'hC;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ENABLE,
    SEL_PENDING,
    SEL_SWSET,
    SEL_ACTIVE
  } reg_sel_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [4:0] prio_lowest(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (v[i-1]) idx = 5'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit two-flop synchroniser with a history flop for rising-edge detection.
module irq_sync_edge #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_async,
  output logic [W-1:0] edge_pulse
);

  logic [W-1:0] s1, s2, s3;

  // Synchroniser chain s1->s2 plus history s3, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // One-cycle pulse for each synchronised 0->1 transition.
  always_comb begin
    edge_pulse = s2 & ~s3;
  end

endmodule

// File: rtl/irq_mmio_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits, enable mask,
// registered level interrupt and lowest-index source id.
module irq_mmio_ctrl
  import irq_mmio_pkg::*;
#(
  parameter int unsigned N_SRC = 8,
  parameter logic [31:0] BASE  = DEFAULT_BASE,
  parameter int unsigned ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             interrupt,
  output logic [ID_W-1:0]  irq_id
);

  localparam logic [31:0] A_ENABLE  = BASE + OFF_ENABLE;
  localparam logic [31:0] A_PENDING = BASE + OFF_PENDING;
  localparam logic [31:0] A_SWSET   = BASE + OFF_SWSET;
  localparam logic [31:0] A_ACTIVE  = BASE + OFF_ACTIVE;

  reg_sel_e         sel;
  logic [N_SRC-1:0] enable, pending, active;
  logic [N_SRC-1:0] src_edge, w1c, swset;
  logic             enable_we;
  logic             unused_bits;

  // Byte-lane bits and upper write-data bits carry no meaning here.
  assign unused_bits = ^{DataAdr[1:0], WriteData};

  irq_sync_edge #(
    .W(N_SRC)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .d_async   (irq_src),
    .edge_pulse(src_edge)
  );

  // Word-address decode of the register window.
  always_comb begin
    sel = SEL_NONE;
    if      (DataAdr[31:2] == A_ENABLE[31:2])  sel = SEL_ENABLE;
    else if (DataAdr[31:2] == A_PENDING[31:2]) sel = SEL_PENDING;
    else if (DataAdr[31:2] == A_SWSET[31:2])   sel = SEL_SWSET;
    else if (DataAdr[31:2] == A_ACTIVE[31:2])  sel = SEL_ACTIVE;
  end

  // Store strobes derived from the decoded register.
  always_comb begin
    enable_we = MemWrite && (sel == SEL_ENABLE);
    w1c       = (MemWrite && (sel == SEL_PENDING)) ? WriteData[N_SRC-1:0] : '0;
    swset     = (MemWrite && (sel == SEL_SWSET))   ? WriteData[N_SRC-1:0] : '0;
    active    = pending & enable;
  end

  // Register state and registered interrupt outputs; sets win over W1C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable    <= '0;
      pending   <= '0;
      interrupt <= 1'b0;
      irq_id    <= '0;
    end else begin
      if (enable_we) enable <= WriteData[N_SRC-1:0];
      pending   <= (pending & ~w1c) | src_edge | swset;
      interrupt <= |active;
      irq_id    <= ID_W'(prio_lowest(32'(active)));
    end
  end

  // Combinational read mux; unmapped and write-only registers read 0.
  always_comb begin
    ReadData = '0;
    unique case (sel)
      SEL_ENABLE:  ReadData = 32'(enable);
      SEL_PENDING: ReadData = 32'(pending);
      SEL_ACTIVE: begin
        ReadData[0]            = |pending;
        ReadData[8]            = interrupt;
        ReadData[ID_W+15:16]   = irq_id;
      end
      default:     ReadData = '0;
    endcase
  end

endmodule
